// File: rtl/vector_decode_sequencer.sv
// vector_decode_sequencer
//   Decodes one instruction into a registered control word and issues it for
//   one beat, or for VEC_BEATS consecutive beats for vector memory ops
//   (strv/ldrv). Stall holds everything; Flush squashes the in-flight word.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   InValid/InReady   instruction handshake; InReady is combinational
//   Opcode, Func      instruction fields
//   Stall, Flush      downstream hold / squash (Flush wins)
//   OutValid          registered control word valid
//   RegW..ALUSrc,
//   RegSrc, ImmSrc    control word (all zero whenever OutValid=0)
//   BeatIdx, LastBeat beat position of the issued instruction
//   Illegal           undecodable opcode (issued as a single beat)
module vector_decode_sequencer #(
  parameter int VEC_BEATS = 4,
  parameter int BW        = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          InValid,
  input  logic [5:0]    Opcode,
  input  logic [2:0]    Func,
  input  logic          Stall,
  input  logic          Flush,
  output logic          InReady,
  output logic          OutValid,
  output logic          RegW,
  output logic          RegWV,
  output logic          MemtoReg,
  output logic          MemW,
  output logic          MemSrc,
  output logic          MemData,
  output logic          MemDataV,
  output logic          VecData,
  output logic          Branch,
  output logic          ALUOp,
  output logic          ALUSrc,
  output logic [1:0]    RegSrc,
  output logic [1:0]    ImmSrc,
  output logic [BW-1:0] BeatIdx,
  output logic          LastBeat,
  output logic          Illegal
);

  typedef struct packed {
    logic       regW, regWV, memtoReg, memW, memSrc, memData, memDataV,
                vecData, branch, aluOp, aluSrc;
    logic [1:0] regSrc, immSrc;
  } ctrl_t;

  localparam logic [BW-1:0] LAST_BEAT = BW'(VEC_BEATS - 1);

  ctrl_t         decCtrl, ctrlQ;
  logic          decIllegal, decMulti;
  logic          outValidQ, illegalQ, multiQ, lastQ;
  logic [BW-1:0] beatQ;
  logic          seqActive;

  // Opcode decode. Bit strings read RegW..ALUSrc, then RegSrc, ImmSrc.
  always_comb begin
    decCtrl    = '0;
    decIllegal = 1'b0;
    decMulti   = 1'b0;
    casez (Opcode)
      6'b000000: decCtrl = (Func[1:0] == 2'b11) ? ctrl_t'({11'b10000000011, 2'b00, 2'b11})
                                                : ctrl_t'({11'b10000000010, 2'b00, 2'b00});
      6'b100000: decCtrl = ctrl_t'({11'b01100000010, 2'b00, 2'b00});
      6'b0010??: decCtrl = ctrl_t'({11'b10000000011, 2'b00, 2'b00});
      6'b011000: decCtrl = ctrl_t'({11'b00010000001, 2'b01, 2'b00});
      6'b011001: decCtrl = ctrl_t'({11'b10100000001, 2'b00, 2'b00});
      6'b111000: begin
        decCtrl  = ctrl_t'({11'b00011000001, 2'b01, 2'b00});
        decMulti = (VEC_BEATS > 1);
      end
      6'b111001: begin
        decCtrl  = ctrl_t'({11'b01101001001, 2'b00, 2'b00});
        decMulti = (VEC_BEATS > 1);
      end
      6'b00110?: decCtrl = ctrl_t'({11'b00000000110, 2'b01, 2'b00});
      6'b000100: decCtrl = ctrl_t'({11'b00000000100, 2'b00, 2'b01});
      default:   decIllegal = 1'b1;
    endcase
  end

  // A multi-beat op still has beats to issue; no new instruction until the
  // final beat is on the outputs, which lets the next one issue bubble-free.
  assign seqActive = outValidQ && multiQ && !lastQ;
  assign InReady   = !Stall && !Flush && !seqActive;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      ctrlQ     <= '0;
      illegalQ  <= 1'b0;
      multiQ    <= 1'b0;
      beatQ     <= '0;
      lastQ     <= 1'b0;
    end else if (Flush) begin
      outValidQ <= 1'b0;
      ctrlQ     <= '0;
      illegalQ  <= 1'b0;
      multiQ    <= 1'b0;
      beatQ     <= '0;
      lastQ     <= 1'b0;
    end else if (Stall) begin
      // hold everything
    end else if (seqActive) begin
      // beatQ < LAST_BEAT here, so the increment never wraps
      beatQ <= beatQ + 1'b1;
      lastQ <= ((beatQ + 1'b1) == LAST_BEAT);
    end else if (InValid) begin
      outValidQ <= 1'b1;
      ctrlQ     <= decCtrl;
      illegalQ  <= decIllegal;
      multiQ    <= decMulti;
      beatQ     <= '0;
      lastQ     <= !decMulti;
    end else begin
      // idle: clearing the word keeps controls at zero while not valid
      outValidQ <= 1'b0;
      ctrlQ     <= '0;
      illegalQ  <= 1'b0;
      multiQ    <= 1'b0;
      beatQ     <= '0;
      lastQ     <= 1'b0;
    end
  end

  assign OutValid = outValidQ;
  assign RegW     = ctrlQ.regW;
  assign RegWV    = ctrlQ.regWV;
  assign MemtoReg = ctrlQ.memtoReg;
  assign MemW     = ctrlQ.memW;
  assign MemSrc   = ctrlQ.memSrc;
  assign MemData  = ctrlQ.memData;
  assign MemDataV = ctrlQ.memDataV;
  assign VecData  = ctrlQ.vecData;
  assign Branch   = ctrlQ.branch;
  assign ALUOp    = ctrlQ.aluOp;
  assign ALUSrc   = ctrlQ.aluSrc;
  assign RegSrc   = ctrlQ.regSrc;
  assign ImmSrc   = ctrlQ.immSrc;
  assign BeatIdx  = beatQ;
  assign LastBeat = lastQ;
  assign Illegal  = illegalQ;

endmodule

// File: tb/tb_vector_decode_sequencer.sv
// Drives one stimulus stream into two instances (VEC_BEATS=4 and 1) and
// checks each against its own expected-beat queue.
module tb_vector_decode_sequencer;

  localparam int VBA = 4;

  // {OutValid, word[14:0], Illegal, BeatIdx[1:0], LastBeat}
  typedef logic [19:0] obs_t;
  typedef struct packed {
    logic [14:0] w;
    logic        ill;
    logic [1:0]  beat;
    logic        last;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic InValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
  logic [5:0] Opcode = '0;
  logic [2:0] Func = '0;

  logic InReadyA, OutValidA, RegWA, RegWVA, MemtoRegA, MemWA, MemSrcA, MemDataA,
        MemDataVA, VecDataA, BranchA, ALUOpA, ALUSrcA, LastBeatA, IllegalA;
  logic [1:0] RegSrcA, ImmSrcA, BeatIdxA;
  logic InReadyB, OutValidB, RegWB, RegWVB, MemtoRegB, MemWB, MemSrcB, MemDataB,
        MemDataVB, VecDataB, BranchB, ALUOpB, ALUSrcB, LastBeatB, IllegalB;
  logic [1:0] RegSrcB, ImmSrcB;
  logic [0:0] BeatIdxB;

  vector_decode_sequencer #(.VEC_BEATS(VBA)) dutA (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Opcode(Opcode), .Func(Func),
    .Stall(Stall), .Flush(Flush), .InReady(InReadyA), .OutValid(OutValidA),
    .RegW(RegWA), .RegWV(RegWVA), .MemtoReg(MemtoRegA), .MemW(MemWA),
    .MemSrc(MemSrcA), .MemData(MemDataA), .MemDataV(MemDataVA), .VecData(VecDataA),
    .Branch(BranchA), .ALUOp(ALUOpA), .ALUSrc(ALUSrcA), .RegSrc(RegSrcA),
    .ImmSrc(ImmSrcA), .BeatIdx(BeatIdxA), .LastBeat(LastBeatA), .Illegal(IllegalA));

  vector_decode_sequencer #(.VEC_BEATS(1)) dutB (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .Opcode(Opcode), .Func(Func),
    .Stall(Stall), .Flush(Flush), .InReady(InReadyB), .OutValid(OutValidB),
    .RegW(RegWB), .RegWV(RegWVB), .MemtoReg(MemtoRegB), .MemW(MemWB),
    .MemSrc(MemSrcB), .MemData(MemDataB), .MemDataV(MemDataVB), .VecData(VecDataB),
    .Branch(BranchB), .ALUOp(ALUOpB), .ALUSrc(ALUSrcB), .RegSrc(RegSrcB),
    .ImmSrc(ImmSrcB), .BeatIdx(BeatIdxB), .LastBeat(LastBeatB), .Illegal(IllegalB));

  obs_t obsA, obsB;
  assign obsA = {OutValidA, RegWA, RegWVA, MemtoRegA, MemWA, MemSrcA, MemDataA, MemDataVA,
                 VecDataA, BranchA, ALUOpA, ALUSrcA, RegSrcA, ImmSrcA, IllegalA,
                 BeatIdxA, LastBeatA};
  assign obsB = {OutValidB, RegWB, RegWVB, MemtoRegB, MemWB, MemSrcB, MemDataB, MemDataVB,
                 VecDataB, BranchB, ALUOpB, ALUSrcB, RegSrcB, ImmSrcB, IllegalB,
                 1'b0, BeatIdxB, LastBeatB};

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  exp_t qA[$], qB[$];
  obs_t lastA = '0, lastB = '0;

  // Reference decode: {Illegal, RegW..ALUSrc, RegSrc, ImmSrc}
  function automatic logic [15:0] refDec(input logic [5:0] op, input logic [2:0] fn);
    if (op == 6'b000000 && fn[1:0] == 2'b11) return {1'b0, 11'b10000000011, 2'b00, 2'b11};
    if (op == 6'b000000)                     return {1'b0, 11'b10000000010, 2'b00, 2'b00};
    if (op == 6'b100000)                     return {1'b0, 11'b01100000010, 2'b00, 2'b00};
    if (op[5:2] == 4'b0010)                  return {1'b0, 11'b10000000011, 2'b00, 2'b00};
    if (op == 6'b011000)                     return {1'b0, 11'b00010000001, 2'b01, 2'b00};
    if (op == 6'b011001)                     return {1'b0, 11'b10100000001, 2'b00, 2'b00};
    if (op == 6'b111000)                     return {1'b0, 11'b00011000001, 2'b01, 2'b00};
    if (op == 6'b111001)                     return {1'b0, 11'b01101001001, 2'b00, 2'b00};
    if (op == 6'b001100 || op == 6'b001101)  return {1'b0, 11'b00000000110, 2'b01, 2'b00};
    if (op == 6'b000100)                     return {1'b0, 11'b00000000100, 2'b00, 2'b01};
    return {1'b1, 15'b0};
  endfunction

  task automatic cmp(input string tag, input obs_t got, input obs_t want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic cmpBit(input string tag, input logic got, input logic want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, want);
    end
  endtask

  // Push the expected beats of the instruction currently on the inputs.
  task automatic pushBeats(input bit isA);
    logic [15:0] r;
    int n;
    exp_t e;
    r = refDec(Opcode, Func);
    n = (isA && (Opcode == 6'b111000 || Opcode == 6'b111001)) ? VBA : 1;
    for (int i = 0; i < n; i++) begin
      e.w = r[14:0]; e.ill = r[15]; e.beat = 2'(i); e.last = (i == n - 1);
      if (isA) qA.push_back(e); else qB.push_back(e);
    end
  endtask

  // One clock: check InReady, advance, then compare each DUT to its model.
  task automatic tick(input string tag);
    bit   rdyA, rdyB;
    obs_t ea, eb;
    exp_t e;
    #1;
    rdyA = !Stall && !Flush && qA.size() == 0;
    rdyB = !Stall && !Flush && qB.size() == 0;
    cmpBit({tag, ".rdyA"}, InReadyA, rdyA);
    cmpBit({tag, ".rdyB"}, InReadyB, rdyB);
    @(posedge clk); #1;
    if (Flush) begin
      qA.delete(); qB.delete(); ea = '0; eb = '0;
    end else if (Stall) begin
      ea = lastA; eb = lastB;
    end else begin
      if (InValid && rdyA) pushBeats(1'b1);
      if (InValid && rdyB) pushBeats(1'b0);
      if (qA.size() > 0) begin e = qA.pop_front(); ea = {1'b1, e}; end else ea = '0;
      if (qB.size() > 0) begin e = qB.pop_front(); eb = {1'b1, e}; end else eb = '0;
    end
    cmp({tag, ".A"}, obsA, ea);
    cmp({tag, ".B"}, obsB, eb);
    lastA = ea; lastB = eb;
  endtask

  task automatic issue(input logic [5:0] op, input logic [2:0] fn);
    InValid = 1'b1; Opcode = op; Func = fn;
  endtask

  initial begin
    // reset state
    #2;
    cmp("rst.A", obsA, '0);
    cmp("rst.B", obsB, '0);
    cmpBit("rst.rdyA", InReadyA, 1'b1);
    cmpBit("rst.rdyB", InReadyB, 1'b1);
    #10 rst_n = 1'b1;

    // single-beat ldr, one-cycle latency
    issue(6'b011001, 3'd0); tick("ldr");
    InValid = 1'b0;         tick("idle1");

    // strv multi-beat, ldr queued and taken on the last beat
    issue(6'b111000, 3'd0); tick("strv.b0");
    issue(6'b011001, 3'd0); tick("strv.b1");
    tick("strv.b2"); tick("strv.b3"); tick("ldr.b2b");
    InValid = 1'b0;  tick("idle2");

    // stall at beat 1 for two cycles
    issue(6'b111001, 3'd0); tick("st.b0");
    InValid = 1'b0;         tick("st.b1");
    Stall = 1'b1; tick("st.hold1"); tick("st.hold2");
    Stall = 1'b0; tick("st.b2"); tick("st.b3"); tick("idle3");

    // flush at beat 2
    issue(6'b111000, 3'd0); tick("fl.b0");
    InValid = 1'b0;         tick("fl.b1"); tick("fl.b2");
    Flush = 1'b1; tick("fl.flush");
    Flush = 1'b0; tick("idle4");

    // flush and stall together
    issue(6'b111001, 3'd0); tick("fs.b0");
    InValid = 1'b0; Flush = 1'b1; Stall = 1'b1; tick("fs.both");
    Flush = 1'b0; Stall = 1'b0; tick("idle5");

    // illegal opcode
    issue(6'b110000, 3'd0); tick("illegal");
    InValid = 1'b0;         tick("idle6");

    // reset mid-ldrv clears outputs immediately
    issue(6'b111001, 3'd0); tick("rs.b0");
    InValid = 1'b0;         tick("rs.b1");
    rst_n = 1'b0; #1;
    cmp("rstMid.A", obsA, '0);
    cmp("rstMid.B", obsB, '0);
    qA.delete(); qB.delete(); lastA = '0; lastB = '0;
    tick("inRst");
    rst_n = 1'b1;
    issue(6'b111001, 3'd0); tick("postRst.b0");
    InValid = 1'b0;         tick("postRst.b1");
    for (int k = 0; k < 8 && (qA.size() > 0 || qB.size() > 0); k++) tick("postRst.drain");

    // full decode sweep on both instances
    for (int op = 0; op < 64; op++) begin
      for (int fn = 0; fn < 8; fn++) begin
        issue(6'(op), 3'(fn)); tick("sweep");
        InValid = 1'b0;
        for (int k = 0; k < 8 && (qA.size() > 0 || qB.size() > 0); k++) tick("sweep.drain");
        total++;
        assert (qA.size() == 0 && qB.size() == 0) else begin
          bad++;
          $error("FAIL sweep.timeout: observed=%0d/%0d expected=0/0", qA.size(), qB.size());
        end
      end
    end
    tick("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_decode_sequencer.md
VECTOR_DECODE_SEQUENCER -- requirements
Module: vector_decode_sequencer

Interface
REQ-001 Parameter VEC_BEATS SHALL default to 4; it is the number of beats per vector memory op and must be >= 1.
REQ-002 Parameter BW SHALL equal max(1, clog2(VEC_BEATS)); it is the beat index width.
REQ-003 Ports SHALL be exactly these (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- InValid  in  1  an instruction is presented.
- Opcode  in  6  instruction opcode.
- Func  in  3  function field.
- Stall  in  1  downstream not ready; hold all state.
- Flush  in  1  squash the in-flight instruction.
- InReady  out  1  instruction accepted this cycle if InValid.
- OutValid  out  1  the registered control word is valid.
- RegW, RegWV, MemtoReg, MemW, MemSrc, MemData, MemDataV, VecData, Branch, ALUOp, ALUSrc  out  1 each  control bits.
- RegSrc, ImmSrc  out  2 each  control fields.
- BeatIdx  out  BW  current beat of the issued instruction.
- LastBeat  out  1  the current beat is the final beat.
- Illegal  out  1  the opcode is undecodable.

Function
REQ-004 Decode SHALL be deterministic; no output ever takes X. Fields are listed as RegW RegWV MemtoReg MemW MemSrc MemData MemDataV VecData Branch ALUOp ALUSrc | RegSrc ImmSrc.
REQ-005 Opcode 000000 with Func[1:0]=11 (sll/slr) SHALL give 10000000011|00 11.
REQ-006 Opcode 000000 with any other Func SHALL give 10000000010|00 00.
REQ-007 Opcode 100000 (vector ALU) SHALL give 01100000010|00 00.
REQ-008 Opcode 0010xx (immediate ALU) SHALL give 10000000011|00 00.
REQ-009 Opcode 011000 (str) SHALL give 00010000001|01 00.
REQ-010 Opcode 011001 (ldr) SHALL give 10100000001|00 00.
REQ-011 Opcode 111000 (strv) SHALL give 00011000001|01 00.
REQ-012 Opcode 111001 (ldrv) SHALL give 01101001001|00 00.
REQ-013 Opcodes 001100 (beq) and 001101 (bgt) SHALL give 00000000110|01 00.
REQ-014 Opcode 000100 (b) SHALL give 00000000100|00 01.
REQ-015 Any other opcode SHALL give all control outputs 0 and Illegal=1 for one beat; Illegal SHALL be 0 for every legal opcode.
REQ-016 strv and ldrv SHALL be multi-beat and issue VEC_BEATS consecutive beats. All other opcodes SHALL be single-beat.
REQ-017 Define seq_active = OutValid and multi-beat and not LastBeat.
REQ-018 InReady SHALL equal !Stall && !Flush && !seq_active, combinationally.
REQ-019 Each rising clk edge SHALL apply the first matching rule, in this priority order:
- Flush: OutValid=0, BeatIdx=0, LastBeat=0.
- Else Stall: all outputs hold.
- Else seq_active: BeatIdx+1, control word held, LastBeat=(BeatIdx+1==VEC_BEATS-1).
- Else InValid: load the decoded word, OutValid=1, BeatIdx=0, LastBeat=(single-beat or VEC_BEATS==1).
- Else: OutValid=0, BeatIdx=0, LastBeat=0.
REQ-020 Single-beat instructions SHALL have LastBeat=1; the latency from accept to OutValid SHALL be exactly 1 cycle.
REQ-021 A new instruction SHALL be accepted in the same cycle that the last beat advances, giving back-to-back issue with no bubble.
REQ-022 When OutValid=0, the control outputs SHALL be 0.
REQ-023 BeatIdx SHALL never exceed VEC_BEATS-1 and SHALL never wrap within a sequence.
REQ-024 Flush and Stall asserted together SHALL resolve as Flush.

Reset
REQ-025 While rst_n=0, all outputs SHALL be 0 asynchronously, including OutValid, BeatIdx, LastBeat and Illegal. InReady SHALL then follow REQ-018.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence. The first instruction after reset release starts at BeatIdx=0.

Verification
REQ-027 Single-beat issue: InValid=1, Opcode=011001 -> next cycle OutValid=1, RegW=1, MemtoReg=1, ALUSrc=1, LastBeat=1.
REQ-028 Multi-beat issue with VEC_BEATS=4: strv accepted -> BeatIdx 0,1,2,3 on consecutive cycles, LastBeat only at 3, and InReady=0 for the 3 cycles covering beats 0-2. A following ldr is accepted during beat 3 and appears the next cycle.
REQ-029 Stall during a sequence: Stall=1 at BeatIdx=1 for 2 cycles -> BeatIdx stays 1 and outputs are stable; the sequence resumes at 2 after release.
REQ-030 Flush during a sequence: Flush at BeatIdx=2 -> next cycle OutValid=0 and BeatIdx=0. Flush with Stall together -> the flush wins.
REQ-031 Illegal opcode and reset: Opcode=110000 -> Illegal=1 with all control bits 0. rst_n low mid-ldrv -> all outputs 0 immediately.
REQ-032 Decode sweep: all 64 opcodes x 8 Func values -> every output matches REQ-005..REQ-015 and no output is ever X. Repeat with VEC_BEATS=1 (strv single-beat, LastBeat=1).
